instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Upstream stage of the LEGv8 core: owns the PC, fetches 32-bit instructions from instruction memory over a valid/ready request and response interface, and presents one instruction at a time to the decode/control stage.
- Consumes the control stage's BrTaken/UncondBr decisions at retire and computes the next PC: sequential, B (imm26), or CBZ/B.cond (imm19).
- Replaces the combinational PC/ROM path so the core tolerates multi-cycle instruction memory.

Parameters:
- ADDR_W, 64, PC and memory address width
- RESET_PC, 64'h0, first fetch address (bits [1:0] must be 0)
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  synchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  32  fetched instruction
- instr  out  32  instruction to decode/control
- instr_valid  out  1  instr is valid and held stable
- instr_ready  in  1  core retires instr this cycle; br_taken/uncond_br valid
- br_taken  in  1  BrTaken from control stage
- uncond_br  in  1  UncondBr from control stage (1 = imm26, 0 = imm19)
- halt  in  1  suppress new fetch requests
- pc  out  ADDR_W  address of current/next instruction
- retired  out  CNT_W  count of retired instructions, wraps
- spurious_rsp  out  1  sticky: response arrived outside WAIT

Behaviour:
- Reset (reset_n=0 at edge): state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, retired=0, spurious_rsp=0. imem_req_valid is combinational, so it is 0 whenever reset_n=0.
- Reset mid-operation abandons any outstanding request. Instruction memory shares reset_n and drops in-flight responses.
- FETCH:
  - imem_req_valid = ~halt; imem_addr = pc.
  - req_valid & req_ready -> WAIT.
  - halt=1 holds in FETCH with no request; deasserting halt resumes fetch.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid: instr <= imem_rsp_data, instr_valid <= 1 -> ISSUE.
  - A response never arrives in the same cycle its request is accepted.
- ISSUE:
  - instr and instr_valid are held stable until instr_ready.
  - On instr_ready: pc <= pc_next, retired <= retired+1, instr_valid <= 0 -> FETCH.
  - instr itself keeps its last value.
- pc_next, computed from the held instr:
  - br_taken=0: pc+4.
  - br_taken=1, uncond_br=1: pc + (sext(instr[25:0]) << 2).
  - br_taken=1, uncond_br=0: pc + (sext(instr[23:5]) << 2).
  - All arithmetic is ADDR_W-bit modulo 2^ADDR_W, so wrap-around is silent. pc stays word-aligned.
- br_taken and uncond_br are sampled only in the instr_ready cycle of ISSUE and ignored otherwise; X on them outside that cycle must not propagate.
- instr_ready outside ISSUE: ignored.
- imem_rsp_valid in FETCH or ISSUE: data discarded, spurious_rsp <= 1. It clears only on reset.
- halt has no effect in WAIT or ISSUE: the in-flight instruction completes and retires normally.
- Latency: a minimum of 3 cycles per instruction (FETCH accept, WAIT response, ISSUE retire with instr_ready already high).
- retired wraps from 2^CNT_W-1 to 0.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch_state_t enum {FETCH, WAIT, ISSUE}
  - INSTR_W=32 and the opcode constants also used by the control decoder
  - PC_INCR=4
  - IMM26_MSB/IMM19 field bound constants
- One combinational sub-module, branch_target. Inputs: pc, instr, br_taken, uncond_br. Output: pc_next. It is reusable by the pipelined core.

Test Plan:
- Reset release, RESET_PC=0, zero-wait memory, instr_ready=1 -> addresses 0,4,8 requested; retired=3 after 9 cycles; instr_valid=0 during reset.
- B with imm26=-2 (instr 0x17FFFFFE) at pc=0x40, br_taken=1, uncond_br=1 -> next imem_addr=0x38.
- CBZ with imm19=+3 at pc=0x100, br_taken=1, uncond_br=0 -> next addr 0x10C; same instruction with br_taken=0 -> next addr 0x104.
- Response delayed 5 cycles and instr_ready held low 4 cycles in ISSUE -> instr stable throughout, no new request, pc unchanged until retire.
- halt=1 in FETCH -> imem_req_valid stays 0; halt asserted during WAIT -> instruction still delivered and retired, then fetch stops.
- Extra rsp_valid in ISSUE -> spurious_rsp=1 and instr unchanged; pc=0xFFFF_FFFF_FFFF_FFFC sequential -> next pc=0; reset_n low during WAIT -> pc=RESET_PC and state FETCH the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the LEGv8 core: fetch FSM states, instruction field
// bounds, the PC increment and the opcode constants used by the control decoder.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_INCR = 4;

  // Branch immediate fields: B uses instr[25:0], CBZ/CBNZ/B.cond use instr[23:5].
  localparam int unsigned IMM26_MSB = 25;
  localparam int unsigned IMM26_W   = IMM26_MSB + 1;
  localparam int unsigned IMM19_MSB = 23;
  localparam int unsigned IMM19_LSB = 5;
  localparam int unsigned IMM19_W   = IMM19_MSB - IMM19_LSB + 1;

  // Opcodes, left-aligned in instr[31:21] and matched on their significant bits.
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;

endpackage

// File: rtl/branch_target.sv
// Next-PC computation for the LEGv8 core.
//   pc        in   current instruction address
//   instr     in   instruction at pc (branch immediates are taken from it)
//   br_taken  in   1 = branch, 0 = sequential
//   uncond_br in   1 = imm26 (B), 0 = imm19 (CBZ/CBNZ/B.cond)
//   pc_next   out  address of the following instruction
// Purely combinational; all sums are modulo 2^ADDR_W.
module branch_target
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               br_taken,
  input  logic               uncond_br,
  output logic [ADDR_W-1:0]  pc_next
);

  logic [ADDR_W-1:0] imm26_off;
  logic [ADDR_W-1:0] imm19_off;

  // Sign-extend the word offset and scale it to bytes.
  assign imm26_off = {{(ADDR_W - IMM26_W - 2){instr[IMM26_MSB]}}, instr[IMM26_MSB:0], 2'b00};
  assign imm19_off = {{(ADDR_W - IMM19_W - 2){instr[IMM19_MSB]}},
                      instr[IMM19_MSB:IMM19_LSB], 2'b00};

  always_comb begin
    pc_next = pc + ADDR_W'(PC_INCR);
    if (br_taken) begin
      pc_next = pc + (uncond_br ? imm26_off : imm19_off);
    end
  end

  // Opcode bits do not affect the target.
  logic unused_opcode;
  assign unused_opcode = ^instr[INSTR_W-1:IMM26_W];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage of the LEGv8 core. Owns the PC, fetches one 32-bit
// instruction at a time from instruction memory and holds it for decode until
// the core retires it, then advances the PC (sequential or branch).
//   clk, reset_n              clock, synchronous active-low reset
//   imem_req_valid/ready      fetch request handshake, address on imem_addr
//   imem_rsp_valid/data       fetch response
//   instr, instr_valid        held instruction to decode/control
//   instr_ready               core retires instr; br_taken/uncond_br valid then
//   halt                      suppresses new fetch requests
//   pc                        address of current/next instruction
//   retired                   wrapping count of retired instructions
//   spurious_rsp              sticky flag: response arrived outside WAIT
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter int unsigned         CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [INSTR_W-1:0]  imem_rsp_data,
  output logic [INSTR_W-1:0]  instr,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                br_taken,
  input  logic                uncond_br,
  input  logic                halt,
  output logic [ADDR_W-1:0]   pc,
  output logic [CNT_W-1:0]    retired,
  output logic                spurious_rsp
);

  // Low address bits are forced to zero so the PC is always word-aligned.
  localparam logic [ADDR_W-1:0] RESET_PC_WORD = {RESET_PC[ADDR_W-1:2], 2'b00};

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               spurious_q, spurious_d;

  logic              retire;
  logic              br_taken_gated;
  logic              uncond_br_gated;
  logic [ADDR_W-1:0] pc_next;

  assign retire = (state_q == ISSUE) && instr_ready;

  // Branch controls are only meaningful in the retire cycle; masking them
  // elsewhere keeps an undriven control stage from leaking X into pc_next.
  assign br_taken_gated  = retire ? br_taken  : 1'b0;
  assign uncond_br_gated = retire ? uncond_br : 1'b0;

  branch_target #(
    .ADDR_W (ADDR_W)
  ) u_branch_target (
    .pc        (pc_q),
    .instr     (instr_q),
    .br_taken  (br_taken_gated),
    .uncond_br (uncond_br_gated),
    .pc_next   (pc_next)
  );

  // Gated by reset_n so no request is visible while the stage is held in reset.
  assign imem_req_valid = reset_n && (state_q == FETCH) && !halt;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    retired_d     = retired_q;
    spurious_d    = spurious_q;

    unique case (state_q)
      FETCH: begin
        if (imem_req_valid && imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_d       = imem_rsp_data;
          instr_valid_d = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          pc_d          = pc_next;
          retired_d     = retired_q + CNT_W'(1);
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // Unexpected response data is dropped but remembered until reset.
    if (imem_rsp_valid && (state_q != WAIT)) begin
      spurious_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC_WORD;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      retired_q     <= '0;
      spurious_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      retired_q     <= retired_d;
      spurious_q    <= spurious_d;
    end
  end

  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign retired      = retired_q;
  assign spurious_rsp = spurious_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. Inputs change on the falling edge and
// outputs are sampled 1ns later, well clear of the rising edge.
module tb_instr_fetch;

  localparam logic [31:0] ADD_I = 32'h8B020020;

  logic        clk;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_taken;
  logic        uncond_br;
  logic        halt;
  logic [63:0] pc;
  logic [31:0] retired;
  logic        spurious_rsp;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  instr_fetch #(
    .ADDR_W   (64),
    .RESET_PC (64'h0),
    .CNT_W    (32)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .br_taken       (br_taken),
    .uncond_br      (uncond_br),
    .halt           (halt),
    .pc             (pc),
    .retired        (retired),
    .spurious_rsp   (spurious_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full fetch/issue/retire transaction starting in FETCH.
  task automatic do_instr(input logic [31:0] data, input int rsp_dly, input int rdy_dly,
                          input logic bt, input logic ub, input logic [63:0] exp_addr,
                          input logic [63:0] exp_next, input logic halt_wait,
                          input logic spur);
    halt = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    chk("req_valid_fetch", {63'd0, imem_req_valid}, 64'd1);
    chk("req_addr", imem_addr, exp_addr);
    @(negedge clk);
    // WAIT: instr_ready here must be ignored.
    halt = halt_wait;
    instr_ready = 1'b1;
    #1;
    chk("req_valid_wait", {63'd0, imem_req_valid}, 64'd0);
    for (int i = 0; i < rsp_dly; i++) begin
      @(negedge clk);
      #1;
      chk("wait_no_req", {63'd0, imem_req_valid}, 64'd0);
      chk("wait_no_valid", {63'd0, instr_valid}, 64'd0);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    @(negedge clk);
    // ISSUE
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = ~data;
    instr_ready    = 1'b0;
    #1;
    chk("issue_instr", {32'd0, instr}, {32'd0, data});
    chk("issue_valid", {63'd0, instr_valid}, 64'd1);
    for (int i = 0; i < rdy_dly; i++) begin
      if (spur && i == 0) imem_rsp_valid = 1'b1;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      #1;
      chk("hold_instr", {32'd0, instr}, {32'd0, data});
      chk("hold_valid", {63'd0, instr_valid}, 64'd1);
      chk("hold_pc", pc, exp_addr);
      chk("hold_no_req", {63'd0, imem_req_valid}, 64'd0);
    end
    if (spur) chk("spurious_set", {63'd0, spurious_rsp}, 64'd1);
    instr_ready = 1'b1;
    br_taken    = bt;
    uncond_br   = ub;
    @(negedge clk);
    instr_ready = 1'b0;
    br_taken    = 1'bx;
    uncond_br   = 1'bx;
    exp_ret++;
    #1;
    chk("retire_valid", {63'd0, instr_valid}, 64'd0);
    chk("retire_pc", pc, exp_next);
    chk("retire_count", {32'd0, retired}, 64'(exp_ret));
    chk("retire_instr_kept", {32'd0, instr}, {32'd0, data});
  endtask

  initial begin
    reset_n        = 1'b0;
    halt           = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    br_taken       = 1'bx;
    uncond_br      = 1'bx;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_pc", pc, 64'h0);
    chk("rst_instr", {32'd0, instr}, 64'd0);
    chk("rst_retired", {32'd0, retired}, 64'd0);
    chk("rst_spurious", {63'd0, spurious_rsp}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Zero-wait sequential fetch: 0, 4, 8.
    do_instr(ADD_I, 0, 0, 1'b0, 1'b0, 64'h0, 64'h4, 1'b0, 1'b0);
    do_instr(ADD_I, 0, 0, 1'b0, 1'b0, 64'h4, 64'h8, 1'b0, 1'b0);
    do_instr(ADD_I, 0, 0, 1'b0, 1'b0, 64'h8, 64'hC, 1'b0, 1'b0);
    chk("retired_three", {32'd0, retired}, 64'd3);

    // B +13 to 0x40, B -2 to 0x38, B +50 to 0x100.
    do_instr(32'h1400000D, 0, 0, 1'b1, 1'b1, 64'hC,  64'h40,  1'b0, 1'b0);
    do_instr(32'h17FFFFFE, 0, 0, 1'b1, 1'b1, 64'h40, 64'h38,  1'b0, 1'b0);
    do_instr(32'h14000032, 0, 0, 1'b1, 1'b1, 64'h38, 64'h100, 1'b0, 1'b0);
    // CBZ imm19=+3 taken, B -3 back, CBZ not taken with slow memory and core.
    do_instr(32'hB4000061, 0, 0, 1'b1, 1'b0, 64'h100, 64'h10C, 1'b0, 1'b0);
    do_instr(32'h17FFFFFD, 0, 0, 1'b1, 1'b1, 64'h10C, 64'h100, 1'b0, 1'b0);
    do_instr(32'hB4000061, 5, 4, 1'b0, 1'b1, 64'h100, 64'h104, 1'b0, 1'b0);
    // B.cond imm19=-1 taken, with a stray response during ISSUE.
    do_instr(32'h54FFFFE0, 0, 2, 1'b1, 1'b0, 64'h104, 64'h100, 1'b0, 1'b1);

    // halt in FETCH blocks requests.
    halt = 1'b1;
    #1;
    chk("halt_no_req", {63'd0, imem_req_valid}, 64'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("halt_still_no_req", {63'd0, imem_req_valid}, 64'd0);
    chk("halt_pc", pc, 64'h100);
    // halt raised during WAIT: instruction completes, then fetch stops.
    do_instr(ADD_I, 1, 0, 1'b0, 1'b0, 64'h100, 64'h104, 1'b1, 1'b0);
    chk("halt_after_retire", {63'd0, imem_req_valid}, 64'd0);
    @(negedge clk);
    #1;
    chk("halt_after_retire2", {63'd0, imem_req_valid}, 64'd0);
    chk("halt_pc_after", pc, 64'h104);
    chk("spurious_sticky", {63'd0, spurious_rsp}, 64'd1);

    // Reset while a request is outstanding.
    halt = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rstw_req_valid", {63'd0, imem_req_valid}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_ret = 0;
    #1;
    chk("rstw_pc", pc, 64'h0);
    chk("rstw_retired", {32'd0, retired}, 64'd0);
    chk("rstw_spurious", {63'd0, spurious_rsp}, 64'd0);
    chk("rstw_instr_valid", {63'd0, instr_valid}, 64'd0);

    // Wrap-around: B -1 from 0, then sequential from the top of memory.
    do_instr(32'h17FFFFFF, 0, 0, 1'b1, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    do_instr(ADD_I, 0, 0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0, 1'b0);
    do_instr(ADD_I, 0, 0, 1'b0, 1'b0, 64'h0, 64'h4, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
